// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// States, stream field sizes and the header range check live here.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_DATA = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam int HDR_BYTES      = 4;
   localparam int BYTES_PER_WORD = 4;
   // Header and data words go through one packer, so size it for the longer field.
   localparam int PACK_BYTES     = (HDR_BYTES > BYTES_PER_WORD) ? HDR_BYTES : BYTES_PER_WORD;

   function automatic logic hdr_too_big(input logic [31:0] n, input logic [31:0] depth);
      return (n > depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus imem write port. The loader uses the master view;
// the host and memory side use the slave view.
interface imem_loader_if #(
   parameter int AW = 12
);
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_in;
   logic          mem_we;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_addr, mem_in, mem_we
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_addr, mem_in, mem_we
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts accepted bytes MSB-first into a 32-bit word; o_word_valid marks the
// cycle in which the final byte is being accepted, with o_word already complete.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_accept,
   input  logic [7:0]  i_data,
   output logic [31:0] o_word,
   output logic        o_word_valid
);
   localparam int CW = $clog2(PACK_BYTES);

   logic [CW-1:0] r_cnt;
   logic [23:0]   r_shift;

   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clr) begin
         r_cnt   <= '0;
         r_shift <= 24'd0;
      end else if (i_accept) begin
         r_shift <= {r_shift[15:0], i_data};
         r_cnt   <= (r_cnt == CW'(PACK_BYTES - 1)) ? '0 : r_cnt + CW'(1);
      end
   end

   always_comb begin
      o_word       = {r_shift, i_data};
      o_word_valid = i_accept && (r_cnt == CW'(PACK_BYTES - 1));
   end

endmodule

// File: rtl/imem_loader.sv
// Fills imem from a host byte stream (header word count, then data words)
// and holds the processor in reset until the whole image is written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int WORD = 4096,
   parameter int AW   = $clog2(WORD)
)(
   input  logic          i_clk,
   input  logic          i_rst,
   imem_loader_if.master io_bus,
   input  logic          i_reload,
   output logic          o_cpu_rst,
   output logic          o_done,
   output logic          o_err,
   output logic [AW:0]   o_loaded
);
   state_e        r_state;
   state_e        w_next_state;
   logic          w_in_ready;
   logic          w_accept;
   logic [31:0]   w_word;
   logic          w_word_valid;
   logic          w_last;

   logic [AW:0]   r_n;
   logic [AW-1:0] r_wcnt;
   logic [AW:0]   r_loaded;
   logic [AW-1:0] r_mem_addr;
   logic [31:0]   r_mem_in;
   logic          r_mem_we;
   logic          r_cpu_rst;
   logic          r_done;
   logic          r_err;

   imem_loader_byte_packer u_packer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clr        (i_reload),
      .i_accept     (w_accept),
      .i_data       (io_bus.in_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // Handshake and last-word detection.
   always_comb begin
      w_in_ready = i_rst && !i_reload && ((r_state == ST_HDR) || (r_state == ST_DATA));
      w_accept   = io_bus.in_valid && w_in_ready;
      w_last     = ({1'b0, r_wcnt} == (r_n - {{AW{1'b0}}, 1'b1}));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= ST_HDR;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (i_reload) begin
         w_next_state = ST_HDR;
      end else begin
         case (r_state)
            ST_HDR: begin
               if (!w_word_valid) begin
                  w_next_state = ST_HDR;
               end else if (w_word == 32'd0) begin
                  w_next_state = ST_DONE;
               end else if (hdr_too_big(w_word, 32'(WORD))) begin
                  w_next_state = ST_ERR;
               end else begin
                  w_next_state = ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_word_valid && w_last) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_DATA;
               end
            end
            ST_DONE: w_next_state = ST_DONE;
            ST_ERR:  w_next_state = ST_ERR;
            default: w_next_state = ST_HDR;
         endcase
      end
   end

   // Counters, imem write port and status flags; status follows the next state
   // so cpu_rst drops in the same cycle the final word is written.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_n        <= '0;
         r_wcnt     <= '0;
         r_loaded   <= '0;
         r_mem_addr <= '0;
         r_mem_in   <= 32'd0;
         r_mem_we   <= 1'b0;
         r_cpu_rst  <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_mem_we  <= 1'b0;
         r_cpu_rst <= (w_next_state != ST_DONE);
         r_done    <= (w_next_state == ST_DONE);
         r_err     <= (w_next_state == ST_ERR);
         if (i_reload) begin
            r_n      <= '0;
            r_wcnt   <= '0;
            r_loaded <= '0;
         end else if (w_word_valid && (r_state == ST_HDR)) begin
            r_n    <= w_word[AW:0];
            r_wcnt <= '0;
         end else if (w_word_valid && (r_state == ST_DATA)) begin
            r_mem_in   <= w_word;
            r_mem_addr <= r_wcnt;
            r_mem_we   <= 1'b1;
            r_wcnt     <= r_wcnt + {{(AW-1){1'b0}}, 1'b1};
            r_loaded   <= r_loaded + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   assign io_bus.in_ready = w_in_ready;
   assign io_bus.mem_addr = r_mem_addr;
   assign io_bus.mem_in   = r_mem_in;
   assign io_bus.mem_we   = r_mem_we;
   assign o_cpu_rst       = r_cpu_rst;
   assign o_done          = r_done;
   assign o_err           = r_err;
   assign o_loaded        = r_loaded;

endmodule
